// File: rtl/unsigned_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per request.
// Optional divide-by-zero flag port enabled by defining DIV_ZERO_FLAG_EN.
module unsigned_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   remd_q, remd_d;

  logic [WIDTH:0]     shiftHi;
  logic [WIDTH+1:0]   diffWide;
  logic               borrow;
  logic [WIDTH-1:0]   newHi;
  logic [WIDTH-1:0]   newLo;

  // The bit shifted out of the partial remainder is kept as a carry so large divisors stay exact.
  always_comb begin
    shiftHi  = rem_q[2*WIDTH-1:WIDTH-1];
    diffWide = {1'b0, shiftHi} - {2'b00, dvsr_q};
    borrow   = diffWide[WIDTH+1];
    newHi    = borrow ? shiftHi[WIDTH-1:0] : diffWide[WIDTH-1:0];
    newLo    = {rem_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvsr_d  = divisor;
          rem_d   = {{WIDTH{1'b0}}, dividend};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = {newHi, newLo};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = newLo;
          remd_d  = newHi;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = remd_q;

`ifdef DIV_ZERO_FLAG_EN
  assign div_zero = (state_q == DONE) && (dvsr_q == '0);
`endif

endmodule

// File: tb/tb_unsigned_divider.sv
// Scoreboard bench for unsigned_divider: expected quotient/remainder queued at issue, compared at output.
// Also checks div_zero when DIV_ZERO_FLAG_EN is defined.
module tb_unsigned_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] dividendIn;
  logic [W-1:0] divisorIn;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] quotientOut;
  logic [W-1:0] remainderOut;
`ifdef DIV_ZERO_FLAG_EN
  logic         divZero;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;

  unsigned_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .dividend  (dividendIn),
    .divisor   (divisorIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .quotient  (quotientOut),
    .remainder (remainderOut)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero  (divZero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one request for a single accepting edge and queue its expected result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    expT e;
    @(negedge clk);
    checkOutput("in_ready_idle", {63'd0, inReady}, 64'd1);
    dividendIn = a;
    divisorIn  = b;
    inValid    = 1'b1;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.dz = (b == '0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then hand off.
  task automatic collectResult(input int holdCycles);
    int  cycles;
    expT e;
    cycles = 0;
    while (!outValid && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'(W));
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 64'd0, 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    checkOutput("quotient", {32'd0, quotientOut}, {32'd0, e.q});
    checkOutput("remainder", {32'd0, remainderOut}, {32'd0, e.r});
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("div_zero", {63'd0, divZero}, {63'd0, e.dz});
`endif
    for (int i = 0; i < holdCycles; i++) begin
      inValid    = i[0];
      dividendIn = 32'd77;
      divisorIn  = 32'd3;
      @(posedge clk);
      #1;
      checkOutput("hold_out_valid", {63'd0, outValid}, 64'd1);
      checkOutput("hold_in_ready", {63'd0, inReady}, 64'd0);
      checkOutput("hold_quotient", {32'd0, quotientOut}, {32'd0, e.q});
      checkOutput("hold_remainder", {32'd0, remainderOut}, {32'd0, e.r});
    end
    inValid = 1'b0;
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("handoff_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("handoff_in_ready", {63'd0, inReady}, 64'd1);
    checkOutput("idle_hold_quotient", {32'd0, quotientOut}, {32'd0, e.q});
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("idle_div_zero", {63'd0, divZero}, 64'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst        = 1'b1;
    inValid    = 1'b0;
    outReady   = 1'b0;
    dividendIn = '0;
    divisorIn  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", {63'd0, inReady}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset_quotient", {32'd0, quotientOut}, 64'd0);
    checkOutput("reset_remainder", {32'd0, remainderOut}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("reset_div_zero", {63'd0, divZero}, 64'd0);
`endif

    applyStimulus(32'd100, 32'd7);                collectResult(0);
    applyStimulus(32'hFFFF_FFFF, 32'd1);          collectResult(0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);  collectResult(0);
    applyStimulus(32'd5, 32'd9);                  collectResult(0);
    applyStimulus(32'd0, 32'd3);                  collectResult(0);
    applyStimulus(32'd1234, 32'd0);               collectResult(0);
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0001);  collectResult(0);
    applyStimulus(32'hDEAD_BEEF, 32'h0001_2345);  collectResult(0);

    applyStimulus(32'd100, 32'd7);                collectResult(10);
    applyStimulus(32'd50, 32'd5);                 collectResult(0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      applyStimulus(ra, rb);
      collectResult(0);
    end

    // Reset in the middle of a computation throws the request away.
    applyStimulus(32'd100, 32'd7);
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    checkOutput("midreset_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("midreset_in_ready", {63'd0, inReady}, 64'd1);
    checkOutput("midreset_quotient", {32'd0, quotientOut}, 64'd0);
    checkOutput("midreset_remainder", {32'd0, remainderOut}, 64'd0);
    repeat (W + 2) @(posedge clk);
    #1;
    checkOutput("midreset_no_result", {63'd0, outValid}, 64'd0);

    applyStimulus(32'd9, 32'd4);                  collectResult(0);

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
